fcmp_dispatch: RTL and testbench

//  Issue stage directly upstream of the FP compare units (Feq/Flt/Fle). Holds the 32-entry FP register

---
 rtl/fcmp_pkg.sv | 59 +++++
 rtl/fcmp_dispatch_if.sv | 55 +++++
 rtl/fp_regfile.sv | 64 ++++++
 rtl/fcmp_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_fcmp_dispatch.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fcmp_pkg.sv
// ---------------------------------------------------------------------------
// fcmp_pkg
// Shared definitions for the FP compare dispatch stage: default widths,
// funct3 encodings of FLE.S/FLT.S/FEQ.S, the dispatch FSM state encoding,
// the one-hot unit-select record and IEEE-754 single NaN classification.
// ---------------------------------------------------------------------------
package fcmp_pkg;

  localparam int FLEN   = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = $clog2(NREG);

  localparam logic [2:0] FCMP_FLE = 3'b000;
  localparam logic [2:0] FCMP_FLT = 3'b001;
  localparam logic [2:0] FCMP_FEQ = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } fcmp_state_e;

  // Which compare unit a request targets; illegal means none of them.
  typedef struct packed {
    logic feq;
    logic flt;
    logic fle;
    logic illegal;
  } fcmp_sel_t;

  // IEEE-754 single field masks.
  localparam logic [31:0] EXP_MASK  = 32'h7F80_0000;
  localparam logic [31:0] MANT_MASK = 32'h007F_FFFF;
  localparam logic [31:0] QUIET_BIT = 32'h0040_0000;

  function automatic fcmp_sel_t decode_funct3(input logic [2:0] funct3);
    fcmp_sel_t sel;
    sel = '0;
    case (funct3)
      FCMP_FEQ: sel.feq     = 1'b1;
      FCMP_FLT: sel.flt     = 1'b1;
      FCMP_FLE: sel.fle     = 1'b1;
      default:  sel.illegal = 1'b1;
    endcase
    return sel;
  endfunction

  // Any NaN: exponent all ones, mantissa non-zero.
  function automatic logic is_nan(input logic [31:0] x);
    return ((x & EXP_MASK) == EXP_MASK) && ((x & MANT_MASK) != 32'h0);
  endfunction

  // Signalling NaN: a NaN whose quiet bit (mantissa MSB) is clear.
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && ((x & QUIET_BIT) == 32'h0);
  endfunction

endpackage

// File: rtl/fcmp_dispatch_if.sv
// ---------------------------------------------------------------------------
// fcmp_dispatch_if
// Request and response channels of the FP compare dispatch stage.
//   req_*  : compare request (valid/ready), funct3, rs1/rs2 operand indices,
//            rd destination index
//   rsp_*  : result to integer writeback (valid/ready), rd, zero-extended
//            compare result, illegal-funct3 error
//   fflags_nv : invalid-operation flag, present only when FCMP_NV_FLAG_EN
//            is defined
// Modports: master = requester/writeback side, slave = dispatch stage.
// ---------------------------------------------------------------------------
interface fcmp_dispatch_if
  import fcmp_pkg::*;
#(
  parameter int FLEN   = fcmp_pkg::FLEN,
  parameter int ADDR_W = fcmp_pkg::ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [ADDR_W-1:0] req_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_rd;
  logic [FLEN-1:0]   rsp_data;
  logic              rsp_err;
`ifdef FCMP_NV_FLAG_EN
  logic              fflags_nv;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err, fflags_nv
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err, fflags_nv
  );
`else
  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err
  );
`endif

endinterface

// File: rtl/fp_regfile.sv
// ---------------------------------------------------------------------------
// fp_regfile
// NREG x FLEN floating-point register file: one write port, two read ports
// with registered outputs. A read that coincides with a write to the same
// index returns the write data (write-first). Contents clear on reset.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rd_en_i                     load both read registers this cycle
//   rd_addr1_i / rd_addr2_i     read indices
//   rd_data1_o / rd_data2_o     registered read data, held while rd_en_i low
//   wr_en_i, wr_addr_i, wr_data_i  write port
// ---------------------------------------------------------------------------
module fp_regfile
  import fcmp_pkg::*;
#(
  parameter int FLEN   = fcmp_pkg::FLEN,
  parameter int NREG   = fcmp_pkg::NREG,
  parameter int ADDR_W = fcmp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [FLEN-1:0]   rd_data1_o,
  output logic [FLEN-1:0]   rd_data2_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [FLEN-1:0]   wr_data_i
);

  logic [FLEN-1:0] mem_q [NREG];
  logic [FLEN-1:0] rd_data1_q;
  logic [FLEN-1:0] rd_data2_q;

  // NOTE: the array is built from flops, not a RAM macro, because every entry
  // must read as zero after reset; a RAM-based version would need a clear
  // sequence instead of an async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the bypass compare below sees this cycle's write, not a half-updated array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else if (rd_en_i) begin
      rd_data1_q <= (wr_en_i && (wr_addr_i == rd_addr1_i)) ? wr_data_i : mem_q[rd_addr1_i];
      rd_data2_q <= (wr_en_i && (wr_addr_i == rd_addr2_i)) ? wr_data_i : mem_q[rd_addr2_i];
    end
  end

  assign rd_data1_o = rd_data1_q;
  assign rd_data2_o = rd_data2_q;

endmodule

// File: rtl/fcmp_dispatch.sv
// ---------------------------------------------------------------------------
// fcmp_dispatch
// Issue stage in front of the combinational FEQ/FLT/FLE units. Holds the FP
// register file, accepts one compare at a time, reads both operands, pulses
// the selected unit enable for one cycle, captures that unit's bit 0 and
// returns it zero-extended with the destination index.
//   IDLE -> READ -> EXEC -> RESP -> IDLE (rsp_valid three cycles after accept)
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   bus (fcmp_dispatch_if.slave)   request / response channels
//   fwr_en, fwr_addr, fwr_data     FP register write, honoured in every state
//   read_data1, read_data2         registered operands to the compare units
//   Feq_en, Flt_en, Fle_en         one-cycle unit enables (EXEC only)
//   eqdata_out, ltdata_out, ledata_out  unit results, bit 0 meaningful
// Build option FCMP_NV_FLAG_EN: adds bus.fflags_nv (invalid-operation flag)
// and forces the result to 0 whenever an operand is NaN.
// ---------------------------------------------------------------------------
module fcmp_dispatch
  import fcmp_pkg::*;
#(
  parameter int FLEN   = fcmp_pkg::FLEN,
  parameter int NREG   = fcmp_pkg::NREG,
  parameter int ADDR_W = fcmp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  fcmp_dispatch_if.slave    bus,
  input  logic              fwr_en,
  input  logic [ADDR_W-1:0] fwr_addr,
  input  logic [FLEN-1:0]   fwr_data,
  output logic [FLEN-1:0]   read_data1,
  output logic [FLEN-1:0]   read_data2,
  output logic              Feq_en,
  output logic              Flt_en,
  output logic              Fle_en,
  input  logic [FLEN-1:0]   eqdata_out,
  input  logic [FLEN-1:0]   ltdata_out,
  input  logic [FLEN-1:0]   ledata_out
);

  fcmp_state_e       state_q, state_d;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              rsp_bit_q;
  logic              rsp_err_q;
  fcmp_sel_t         sel;
  logic              accept;
  logic              rd_en;
  logic              in_exec;
  logic              req_ready;
  logic              rsp_valid;
  logic              result_bit;

  // Only bit 0 of each unit result carries the compare outcome.
  logic unused_unit_bits;
  assign unused_unit_bits = ^{eqdata_out[FLEN-1:1], ltdata_out[FLEN-1:1], ledata_out[FLEN-1:1]};

  assign sel    = decode_funct3(funct3_q);
  assign accept = req_ready && bus.req_valid;

  fp_regfile #(
    .FLEN   (FLEN),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (rd_en),
    .rd_addr1_i (rs1_q),
    .rd_addr2_i (rs2_q),
    .rd_data1_o (read_data1),
    .rd_data2_o (read_data2),
    .wr_en_i    (fwr_en),
    .wr_addr_i  (fwr_addr),
    .wr_data_i  (fwr_data)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; without it this process would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = 1'b0;
    rd_en     = 1'b0;
    in_exec   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_READ: rd_en     = 1'b1;
      ST_EXEC: in_exec   = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign Feq_en = in_exec && sel.feq;
  assign Flt_en = in_exec && sel.flt;
  assign Fle_en = in_exec && sel.fle;

  // Result of the unit selected by funct3; illegal funct3 yields 0.
  always_comb begin
    result_bit = 1'b0;
    if      (sel.feq) result_bit = eqdata_out[0];
    else if (sel.flt) result_bit = ltdata_out[0];
    else if (sel.fle) result_bit = ledata_out[0];
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      funct3_q <= bus.req_funct3;
      rs1_q    <= bus.req_rs1;
      rs2_q    <= bus.req_rs2;
      rd_q     <= bus.req_rd;
    end
  end

`ifdef FCMP_NV_FLAG_EN
  logic any_nan;
  logic nv_d;
  logic nv_q;

  // FEQ is quiet: only signalling NaNs raise invalid. FLT/FLE are signalling
  // comparisons: any NaN raises invalid. Every comparison with a NaN is false.
  assign any_nan = is_nan(read_data1) || is_nan(read_data2);
  assign nv_d    = (sel.feq && (is_snan(read_data1) || is_snan(read_data2))) ||
                   ((sel.flt || sel.fle) && any_nan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_bit_q <= 1'b0;
      rsp_err_q <= 1'b0;
      nv_q      <= 1'b0;
    end else if (in_exec) begin
      rsp_bit_q <= result_bit && !any_nan;
      rsp_err_q <= sel.illegal;
      nv_q      <= nv_d;
    end
  end

  assign bus.fflags_nv = nv_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_bit_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (in_exec) begin
      rsp_bit_q <= result_bit;
      rsp_err_q <= sel.illegal;
    end
  end
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_data  = {{(FLEN-1){1'b0}}, rsp_bit_q};
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fcmp_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fcmp_dispatch
// Self-checking bench for fcmp_dispatch. Models the three compare units with
// sign/magnitude arithmetic on IEEE-754 singles (random junk in the unused
// upper bits), keeps its own copy of the register file, and checks handshake
// timing, enable pulses, operands and responses for directed and random ops.
// Honours FCMP_NV_FLAG_EN.
// ---------------------------------------------------------------------------
module tb_fcmp_dispatch;
  import fcmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fwr_en;
  logic [4:0]  fwr_addr;
  logic [31:0] fwr_data;
  logic [31:0] read_data1, read_data2;
  logic        Feq_en, Flt_en, Fle_en;
  logic [31:0] eqdata_out, ltdata_out, ledata_out;
  logic [30:0] noise;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] model [32];
  logic [31:0] last_data;
  logic        last_err;
  logic        last_nv;

  always #5 clk = ~clk;

  fcmp_dispatch_if bus ();

  fcmp_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fwr_en     (fwr_en),
    .fwr_addr   (fwr_addr),
    .fwr_data   (fwr_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .Feq_en     (Feq_en),
    .Flt_en     (Flt_en),
    .Fle_en     (Fle_en),
    .eqdata_out (eqdata_out),
    .ltdata_out (ltdata_out),
    .ledata_out (ledata_out)
  );

  // ---------------- reference arithmetic ----------------
  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit m_snan(input logic [31:0] x);
    return m_nan(x) && !x[22];
  endfunction

  function automatic bit m_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic bit m_feq(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return 1'b0;
    if (m_zero(a) && m_zero(b)) return 1'b1;
    return a == b;
  endfunction

  function automatic bit m_flt(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return 1'b0;
    if (m_zero(a) && m_zero(b)) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic bit m_fle(input logic [31:0] a, input logic [31:0] b);
    return m_flt(a, b) || m_feq(a, b);
  endfunction

  // Behavioural compare units.
  assign eqdata_out = {noise, m_feq(read_data1, read_data2)};
  assign ltdata_out = {~noise, m_flt(read_data1, read_data2)};
  assign ledata_out = {noise ^ 31'h2AAA_AAAA, m_fle(read_data1, read_data2)};

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 8))
      0: v = $urandom;
      1: v = 32'h3F80_0000;
      2: v = 32'h4020_0000;
      3: v = 32'h0000_0000;
      4: v = 32'h8000_0000;
      5: v = 32'h7FC0_0000;
      6: v = 32'h7FA0_0000;
      7: v = 32'hFF80_0000;
      default: v = 32'hC143_3333;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    fwr_en = 1'b1; fwr_addr = a; fwr_data = d;
    @(posedge clk); #1;
    fwr_en = 1'b0;
    model[a] = d;
  endtask

  // Issues one compare and checks every cycle of it up to the handshake.
  task automatic do_op(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input int hold, input bit byp,
                       input logic [4:0] byp_addr, input logic [31:0] byp_data,
                       input bit late_wr);
    int          n;
    logic [31:0] a, b, exp_data;
    logic [2:0]  exp_en;
    logic        exp_err, exp_nv, r;

    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait: req_ready=%b required 1", bus.req_ready);
      return;
    end

    noise          = $urandom;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_rd     = rd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = $urandom;
    bus.req_rd     = $urandom;
    if (byp) begin
      fwr_en = 1'b1; fwr_addr = byp_addr; fwr_data = byp_data;
      model[byp_addr] = byp_data;
    end

    // READ cycle
    @(negedge clk);
    checks++;
    if ({Feq_en, Flt_en, Fle_en, bus.rsp_valid, bus.req_ready} !== 5'b0) begin
      fails++;
      $display("FAIL read_cycle: en/rsp_valid/req_ready=%b required 00000",
               {Feq_en, Flt_en, Fle_en, bus.rsp_valid, bus.req_ready});
    end
    a = model[rs1];
    b = model[rs2];

    @(posedge clk); #1;
    fwr_en = 1'b0;
    if (late_wr) begin
      fwr_en = 1'b1; fwr_addr = rs1; fwr_data = ~a;
      model[rs1] = ~a;
    end

    // EXEC cycle
    @(negedge clk);
    case (f3)
      FCMP_FEQ: begin exp_en = 3'b100; r = m_feq(a, b); end
      FCMP_FLT: begin exp_en = 3'b010; r = m_flt(a, b); end
      FCMP_FLE: begin exp_en = 3'b001; r = m_fle(a, b); end
      default:  begin exp_en = 3'b000; r = 1'b0; end
    endcase
    exp_err = (exp_en == 3'b000);
    exp_nv  = 1'b0;
`ifdef FCMP_NV_FLAG_EN
    if (m_nan(a) || m_nan(b)) r = 1'b0;
    if (f3 == FCMP_FEQ) exp_nv = m_snan(a) || m_snan(b);
    else if (!exp_err)  exp_nv = m_nan(a) || m_nan(b);
`endif
    exp_data = {31'd0, r};
    checks++;
    if ({Feq_en, Flt_en, Fle_en} !== exp_en) begin
      fails++;
      $display("FAIL exec_enables: {feq,flt,fle}=%b required %b", {Feq_en, Flt_en, Fle_en}, exp_en);
    end
    checks++;
    if ({read_data1, read_data2} !== {a, b}) begin
      fails++;
      $display("FAIL exec_operands: %h %h required %h %h", read_data1, read_data2, a, b);
    end

    @(posedge clk); #1;
    fwr_en        = 1'b0;
    bus.rsp_ready = (hold == 0);
    if (hold > 0) begin
      bus.req_valid  = 1'b1;
      bus.req_funct3 = FCMP_FEQ;
    end

    // First RESP cycle
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_err, bus.req_ready} !==
        {1'b1, rd, exp_data, exp_err, 1'b0}) begin
      fails++;
      $display("FAIL resp: valid=%b rd=%0d data=%h err=%b ready=%b required 1 %0d %h %b 0",
               bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_err, bus.req_ready,
               rd, exp_data, exp_err);
    end
    checks++;
    if ({Feq_en, Flt_en, Fle_en, read_data1} !== {3'b000, a}) begin
      fails++;
      $display("FAIL resp_hold_ops: en=%b rd1=%h required 000 %h",
               {Feq_en, Flt_en, Fle_en}, read_data1, a);
    end
`ifdef FCMP_NV_FLAG_EN
    checks++;
    if (bus.fflags_nv !== exp_nv) begin
      fails++;
      $display("FAIL fflags_nv: %b required %b", bus.fflags_nv, exp_nv);
    end
    last_nv = bus.fflags_nv;
`else
    last_nv = exp_nv;
`endif
    last_data = bus.rsp_data;
    last_err  = bus.rsp_err;

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_err, bus.req_ready} !==
          {1'b1, rd, exp_data, exp_err, 1'b0}) begin
        fails++;
        $display("FAIL resp_stall: valid=%b rd=%0d data=%h err=%b ready=%b required 1 %0d %h %b 0",
                 bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_err, bus.req_ready,
                 rd, exp_data, exp_err);
      end
    end

    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL post_handshake: rsp_valid/req_ready=%b required 01",
               {bus.rsp_valid, bus.req_ready});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    fwr_en = 1'b0; fwr_addr = '0; fwr_data = '0; noise = '0;
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_rd = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, Feq_en, Flt_en, Fle_en, bus.rsp_err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: ready/valid/en/err=%b required 100000",
               {bus.req_ready, bus.rsp_valid, Feq_en, Flt_en, Fle_en, bus.rsp_err});
    end
    checks++;
    if ({read_data1, read_data2, bus.rsp_data, bus.rsp_rd} !== 69'd0) begin
      fails++;
      $display("FAIL reset_data: rd1=%h rd2=%h data=%h rd=%0d required all 0",
               read_data1, read_data2, bus.rsp_data, bus.rsp_rd);
    end
`ifdef FCMP_NV_FLAG_EN
    checks++;
    if (bus.fflags_nv !== 1'b0) begin
      fails++;
      $display("FAIL reset_nv: %b required 0", bus.fflags_nv);
    end
`endif
    // Cleared registers compare equal: +0 == +0.
    do_op(FCMP_FEQ, 5'd7, 5'd8, 5'd3, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (last_data !== 32'd1) begin
      fails++;
      $display("FAIL reset_regfile_feq: %h required 00000001", last_data);
    end
  endtask

  task automatic test_feq();
    write_reg(5'd1, 32'h4020_0000);
    write_reg(5'd2, 32'h4020_0000);
    do_op(FCMP_FEQ, 5'd1, 5'd2, 5'd5, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (last_data !== 32'd1) begin
      fails++;
      $display("FAIL feq_2p5: %h required 00000001", last_data);
    end
  endtask

  task automatic test_flt_fle();
    write_reg(5'd3, 32'hC143_3333);
    write_reg(5'd4, 32'h4160_0000);
    do_op(FCMP_FLT, 5'd3, 5'd4, 5'd10, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (last_data !== 32'd1) begin
      fails++;
      $display("FAIL flt_neg_lt_pos: %h required 00000001", last_data);
    end
    do_op(FCMP_FLE, 5'd4, 5'd3, 5'd11, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (last_data !== 32'd0) begin
      fails++;
      $display("FAIL fle_pos_le_neg: %h required 00000000", last_data);
    end
  endtask

  task automatic test_backpressure();
    do_op(FCMP_FLT, 5'd3, 5'd4, 5'd12, 5, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_bypass();
    // Stale f6 is a quiet NaN so only the forwarded value can compare equal.
    write_reg(5'd6, 32'h7FC0_0000);
    do_op(FCMP_FEQ, 5'd6, 5'd6, 5'd13, 0, 1'b1, 5'd6, 32'h4268_0000, 1'b0);
    checks++;
    if (last_data !== 32'd1) begin
      fails++;
      $display("FAIL bypass_feq: %h required 00000001", last_data);
    end
    // Write during EXEC must not disturb the in-flight operand.
    do_op(FCMP_FEQ, 5'd1, 5'd2, 5'd14, 1, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_illegal();
    do_op(3'b011, 5'd1, 5'd2, 5'd15, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if ({last_err, last_data} !== {1'b1, 32'd0}) begin
      fails++;
      $display("FAIL illegal_funct3: err=%b data=%h required 1 00000000", last_err, last_data);
    end
    do_op(3'b111, 5'd4, 5'd4, 5'd16, 2, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_in_exec();
    int seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = FCMP_FEQ;
    bus.req_rs1 = 5'd1; bus.req_rs2 = 5'd2; bus.req_rd = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (Feq_en !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_exec: Feq_en=%b required 1", Feq_en);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    checks++;
    if ({Feq_en, Flt_en, Fle_en, bus.rsp_valid, bus.req_ready, read_data1} !== {5'b00001, 32'd0}) begin
      fails++;
      $display("FAIL reset_in_exec: en/valid/ready=%b rd1=%h required 00001 0",
               {Feq_en, Flt_en, Fle_en, bus.rsp_valid, bus.req_ready}, read_data1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL dropped_request: %0d bad cycles required 0", seen);
    end
    do_op(FCMP_FEQ, 5'd1, 5'd2, 5'd17, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if ({read_data1, last_data} !== {32'd0, 32'd1}) begin
      fails++;
      $display("FAIL regfile_cleared: rd1=%h data=%h required 0 1", read_data1, last_data);
    end
  endtask

`ifdef FCMP_NV_FLAG_EN
  task automatic test_nv_flag();
    write_reg(5'd20, 32'h7FA0_0000);
    write_reg(5'd21, 32'h3F80_0000);
    write_reg(5'd22, 32'h7FC0_0000);
    do_op(FCMP_FEQ, 5'd20, 5'd21, 5'd1, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if ({last_nv, last_data} !== {1'b1, 32'd0}) begin
      fails++;
      $display("FAIL nv_feq_snan: nv=%b data=%h required 1 0", last_nv, last_data);
    end
    do_op(FCMP_FEQ, 5'd22, 5'd21, 5'd2, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if ({last_nv, last_data} !== {1'b0, 32'd0}) begin
      fails++;
      $display("FAIL nv_feq_qnan: nv=%b data=%h required 0 0", last_nv, last_data);
    end
    do_op(FCMP_FLE, 5'd22, 5'd21, 5'd3, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (last_nv !== 1'b1) begin
      fails++;
      $display("FAIL nv_fle_qnan: nv=%b required 1", last_nv);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] f3;
    logic [4:0] rs1, rs2, ba;
    int         pick;
    for (int i = 0; i < 8; i++) write_reg(5'(i), rand_val());
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(0, 9);
      if (pick < 3)      f3 = FCMP_FLE;
      else if (pick < 6) f3 = FCMP_FLT;
      else if (pick < 9) f3 = FCMP_FEQ;
      else               f3 = 3'($urandom_range(3, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      ba  = ($urandom_range(0, 1) == 0) ? rs1 : rs2;
      do_op(f3, rs1, rs2, 5'($urandom), $urandom_range(0, 2),
            ($urandom_range(0, 3) == 0), ba, rand_val(), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_feq();
    test_flt_fle();
    test_backpressure();
    test_bypass();
    test_illegal();
`ifdef FCMP_NV_FLAG_EN
    test_nv_flag();
`endif
    test_reset_in_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
